// File: rtl/clic_irq_arbiter_if.sv
// ---------------------------------------------------------------------------
// clic_irq_arbiter_if
// Bundles the source-side lines, the one-hot request towards the ID stage and
// the acknowledge handshake of clic_irq_arbiter.
//   src_irq_i    raw interrupt lines, one per source
//   src_ie_i     per-source enable
//   src_edge_i   per-source trigger mode (1 = rising edge, 0 = level)
//   src_level_i  8-bit level per source, source k at [8k+7:8k]
//   irq_o        one-hot request to the ID stage
//   irq_level_o  level of the presented source
//   irq_ack_i    acknowledge pulse from the core
//   ack_valid_o  one-cycle pulse: acknowledge accepted
//   ack_id_o     id of the acknowledged source
// Modports: slave = the arbiter, master = the environment (sources + core).
// ---------------------------------------------------------------------------
interface clic_irq_arbiter_if #(
  parameter int NumInterruptSrc = 256
);
  localparam int IrqIdWidth = $clog2(NumInterruptSrc);

  logic [NumInterruptSrc-1:0]   src_irq_i;
  logic [NumInterruptSrc-1:0]   src_ie_i;
  logic [NumInterruptSrc-1:0]   src_edge_i;
  logic [8*NumInterruptSrc-1:0] src_level_i;
  logic [NumInterruptSrc-1:0]   irq_o;
  logic [7:0]                   irq_level_o;
  logic                         irq_ack_i;
  logic                         ack_valid_o;
  logic [IrqIdWidth-1:0]        ack_id_o;

  modport slave (
    input  src_irq_i, src_ie_i, src_edge_i, src_level_i, irq_ack_i,
    output irq_o, irq_level_o, ack_valid_o, ack_id_o
  );

  modport master (
    output src_irq_i, src_ie_i, src_edge_i, src_level_i, irq_ack_i,
    input  irq_o, irq_level_o, ack_valid_o, ack_id_o
  );
endinterface

// File: rtl/clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// clic_irq_arbiter
// Tracks per-source pending state (edge or level triggered), picks the
// enabled pending source with the highest level (ties to the higher index)
// and presents it to the ID stage as a frozen one-hot request until it is
// acknowledged or withdrawn. A one-cycle cooldown with irq_o = 0 follows
// every presentation so the ID stage sees the request deassert.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     clic_irq_arbiter_if.slave (sources, request, acknowledge)
// ---------------------------------------------------------------------------
module clic_irq_arbiter #(
  parameter int NumInterruptSrc = 256,
  parameter int IrqIdWidth      = $clog2(NumInterruptSrc)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  clic_irq_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    COOLDOWN
  } state_e;

  localparam logic [NumInterruptSrc-1:0] OneLsb = NumInterruptSrc'(1);

  state_e                      state_q, state_d;
  logic [NumInterruptSrc-1:0]  src_prev_q;
  logic [NumInterruptSrc-1:0]  edge_pend_q, edge_pend_d;
  logic [NumInterruptSrc-1:0]  eligible;
  logic [NumInterruptSrc-1:0]  ack_clr;
  logic [IrqIdWidth-1:0]       pres_id_q, pres_id_d;
  logic [7:0]                  level_q, level_d;
  logic [IrqIdWidth-1:0]       win_id;
  logic [7:0]                  win_level;
  logic                        any_eligible;
  logic                        ack_accept;
  logic                        ack_valid_q;
  logic [IrqIdWidth-1:0]       ack_id_q;

  // Edge sources are pending only through their latched pend bit; level
  // sources follow the live line.
  assign eligible = ((edge_pend_q & bus.src_edge_i) | (bus.src_irq_i & ~bus.src_edge_i))
                    & bus.src_ie_i;

  // Linear scan in ascending index with >= so a tie resolves to the higher
  // index; level 0 is a valid winner.
  always_comb begin
    win_id       = '0;
    win_level    = '0;
    any_eligible = 1'b0;
    for (int k = 0; k < NumInterruptSrc; k++) begin
      if (eligible[k] && (bus.src_level_i[8*k +: 8] >= win_level)) begin
        win_id       = IrqIdWidth'(k);
        win_level    = bus.src_level_i[8*k +: 8];
        any_eligible = 1'b1;
      end
    end
  end

  // NOTE: every signal of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pres_id_d  = pres_id_q;
    level_d    = level_q;
    ack_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d   = PRESENT;
          pres_id_d = win_id;
          level_d   = win_level;
        end
      end
      PRESENT: begin
        // Acknowledge outranks a same-cycle withdrawal.
        if (bus.irq_ack_i) begin
          ack_accept = 1'b1;
          state_d    = COOLDOWN;
        end else if (!eligible[pres_id_q]) begin
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // A rising edge in the same cycle as the ack-clear re-arms the pend.
  assign ack_clr     = ack_accept ? (OneLsb << pres_id_q) : '0;
  assign edge_pend_d = (edge_pend_q & ~ack_clr)
                     | (bus.src_irq_i & ~src_prev_q & bus.src_edge_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      src_prev_q  <= '0;
      edge_pend_q <= '0;
      pres_id_q   <= '0;
      level_q     <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      src_prev_q  <= bus.src_irq_i;
      edge_pend_q <= edge_pend_d;
      pres_id_q   <= pres_id_d;
      level_q     <= level_d;
      ack_valid_q <= ack_accept;
      if (ack_accept) begin
        ack_id_q <= pres_id_q;
      end
    end
  end

  // Request is a pure decode of registered state, so it is glitch-free and
  // drops in the same cycle an asynchronous reset is applied.
  assign bus.irq_o       = (state_q == PRESENT) ? (OneLsb << pres_id_q) : '0;
  assign bus.irq_level_o = level_q;
  assign bus.ack_valid_o = ack_valid_q;
  assign bus.ack_id_o    = ack_id_q;

endmodule

// File: doc/clic_irq_arbiter.md
# clic_irq_arbiter

Interrupt arbiter that sits directly upstream of the ID stage and drives its one-hot `irq_i` and `irq_level_i` inputs. It tracks pending state per source, with edge or level triggering selected per source. It picks the highest-level enabled pending source and presents it as a frozen one-hot request until the core acknowledges it or the request is withdrawn. Threshold and `mie` gating are not done here; the ID stage does them.

## Interface
Parameters:
- `NumInterruptSrc`, 256: number of sources; must be ≥2.
- `IrqIdWidth`, `$clog2(NumInterruptSrc)`: width of a source id. Derived; do not override.

Ports:
- `clk_i`  in  1  clock. One clock domain only.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `src_irq_i`  in  NumInterruptSrc  raw interrupt lines, synchronous to `clk_i`.
- `src_ie_i`  in  NumInterruptSrc  per-source enable.
- `src_edge_i`  in  NumInterruptSrc  trigger mode: 1 = rising-edge-triggered, 0 = level-triggered.
- `src_level_i`  in  8*NumInterruptSrc  per-source level; source k uses bits `[8k+7:8k]`.
- `irq_o`  out  NumInterruptSrc  one-hot request to the ID stage.
- `irq_level_o`  out  8  level of the presented source.
- `irq_ack_i`  in  1  core acknowledge pulse (the ID stage's `irq_ack_o`).
- `ack_valid_o`  out  1  one-cycle pulse: an acknowledge was accepted.
- `ack_id_o`  out  IrqIdWidth  id of the acknowledged source; valid when `ack_valid_o` is high.

## Operation
Pending state:
- Edge sources: `edge_pend[k]` is set when `src_irq_i[k]` is 1 and `src_prev_q[k]` was 0. `src_prev_q` holds `src_irq_i` registered by one cycle.
- `edge_pend[k]` is cleared only by an accepted acknowledge of k. If set and clear happen in the same cycle, set wins.
- Level sources: pending equals `src_irq_i[k]` live and is never latched.
- `eligible[k] = pending[k] & src_ie_i[k]`.

Arbitration (combinational, evaluated every cycle):
- The winner is the eligible source with the maximum `src_level_i`.
- Ties go to the higher index.
- Level 0 sources are eligible.

FSM states: IDLE, PRESENT, COOLDOWN.
- **IDLE**
  - If any source is eligible: register the winner into `pres_id_q` and `irq_level_o`, drive `irq_o` as the one-hot of `pres_id_q`, and go to PRESENT.
  - Otherwise `irq_o` is 0.
- **PRESENT**
  - `irq_o` and `irq_level_o` are frozen; a higher-level arrival does not preempt. Freezing keeps the ID stage's registered copy consistent with the acknowledge.
  - If `irq_ack_i` is high: accept the acknowledge, clear `edge_pend[pres_id_q]`, and pulse `ack_valid_o`/`ack_id_o` on the next cycle. Go to COOLDOWN.
  - Else if `eligible[pres_id_q]` is 0 (level line dropped or enable cleared): withdraw the request and go to COOLDOWN without an ack pulse.
  - If an acknowledge and a withdrawal happen in the same cycle, the acknowledge takes priority.
- **COOLDOWN**
  - Lasts exactly 1 cycle with `irq_o` = 0, so the ID stage observes deassertion.
  - Then go to IDLE.
- `irq_ack_i` is ignored in IDLE and COOLDOWN: no pulse, no pending change.

## Timing
- Reset values:
  - FSM = IDLE.
  - `irq_o` = 0, `irq_level_o` = 0.
  - `ack_valid_o` = 0, `ack_id_o` = 0.
  - `edge_pend` = 0, `src_prev_q` = 0.
- Latency, level source asserted in cycle t while IDLE: `irq_o` is valid from t+1.
- Latency, edge source rising in cycle t: `edge_pend` is set at t+1 and `irq_o` is valid from t+2.
- Acknowledge in cycle t while PRESENT:
  - `irq_o` = 0 and `ack_valid_o` = 1 at t+1 (COOLDOWN).
  - Earliest next presentation is at t+3: IDLE at t+2, register at the end of t+2.
- Back-to-back: when two sources are pending, the second is presented 3 cycles after the acknowledge of the first.
- `ack_valid_o` is high for exactly one cycle per accepted acknowledge.
- Reset asserted mid-PRESENT: all state clears immediately and asynchronously. Edge pends are lost; level sources re-present after reset deasserts.
- Edge source that re-rises while presented: the pend is set again, and set wins over an ack-clear in the same cycle. The source is presented again after COOLDOWN.

## Test plan
- Single level source 5, level 0x40, enabled → `irq_o` = 1<<5 and `irq_level_o` = 0x40 one cycle later. Ack → `ack_valid_o` = 1 with `ack_id_o` = 5 next cycle, and `irq_o` = 0 for 1 cycle. The source is re-presented while `src_irq_i[5]` is held.
- Sources 3 (level 0x20) and 7 (level 0x80) asserted together → 7 presented first. Ack → 3 presented exactly 3 cycles after the ack.
- Equal levels 0x10 on sources 2 and 9 → 9 wins. Source 9 disabled (`src_ie_i[9]` = 0) → 2 wins.
- Edge source 4 pulsed for 1 cycle → `irq_o` = 1<<4 two cycles later and stays until ack. After the ack, no re-presentation occurs.
- Withdrawal: level source 6 presented, then `src_irq_i[6]` drops with no ack → `irq_o` = 0 next cycle with no `ack_valid_o`, then IDLE. Variant where the ack and the drop happen in the same cycle → `ack_valid_o` = 1 with `ack_id_o` = 6.
- Preemption check: source 1 (0x10) presented, then source 8 (0xF0) rises → `irq_o` stays 1<<1 until the ack. Additional checks:
  - Ack while IDLE is ignored.
  - `rst_ni` low mid-PRESENT → all outputs 0 in the same cycle.
